// File: rtl/sdram_avl_arbiter.sv
// Two-port round-robin arbiter in front of the sdram_controller Avalon slave port.
// Grants are held for a whole burst, so beats from the two masters never interleave.
module sdram_avl_arbiter #(
  parameter int AW  = 32,
  parameter int DW  = 32,
  parameter int BCW = 8
) (
  input  logic              clk,
  input  logic              rest_n,

  input  logic [AW-1:0]     m0_address,
  input  logic [DW/8-1:0]   m0_byte_en,
  input  logic              m0_write,
  input  logic              m0_read,
  input  logic [DW-1:0]     m0_write_data,
  input  logic              m0_begin_burst_transfer,
  input  logic [BCW-1:0]    m0_burst_count,
  output logic              m0_wait_request,
  output logic [DW-1:0]     m0_read_data,
  output logic              m0_read_data_valid,

  input  logic [AW-1:0]     m1_address,
  input  logic [DW/8-1:0]   m1_byte_en,
  input  logic              m1_write,
  input  logic              m1_read,
  input  logic [DW-1:0]     m1_write_data,
  input  logic              m1_begin_burst_transfer,
  input  logic [BCW-1:0]    m1_burst_count,
  output logic              m1_wait_request,
  output logic [DW-1:0]     m1_read_data,
  output logic              m1_read_data_valid,

  output logic [AW-1:0]     s_address,
  output logic [DW/8-1:0]   s_byte_en,
  output logic              s_write,
  output logic              s_read,
  output logic [DW-1:0]     s_write_data,
  output logic              s_begin_burst_transfer,
  output logic [BCW-1:0]    s_burst_count,
  input  logic              s_wait_request,
  input  logic [DW-1:0]     s_read_data,
  input  logic              s_read_data_valid
);

  typedef enum logic [1:0] {IDLE, WR_BURST, RD_CMD, RD_DATA} state_t;

  localparam logic [BCW-1:0] ONE = BCW'(1);

  state_t         state, state_nx;
  logic           grant, grant_nx;
  logic           last, last_nx;
  logic [BCW-1:0] cnt, cnt_nx;

  logic           req0, req1, pick;
  logic [AW-1:0]  g_address;
  logic [DW/8-1:0] g_byte_en;
  logic           g_write, g_read, g_begin;
  logic [DW-1:0]  g_write_data;
  logic [BCW-1:0] g_burst_count;

  // A burst count of zero still moves one beat.
  function automatic logic [BCW-1:0] eff_len(input logic [BCW-1:0] bc);
    return (bc == '0) ? ONE : bc;
  endfunction

  assign req0 = (m0_write | m0_read) & m0_begin_burst_transfer;
  assign req1 = (m1_write | m1_read) & m1_begin_burst_transfer;

  assign g_address     = grant ? m1_address              : m0_address;
  assign g_byte_en     = grant ? m1_byte_en              : m0_byte_en;
  assign g_write       = grant ? m1_write                : m0_write;
  assign g_read        = grant ? m1_read                 : m0_read;
  assign g_begin       = grant ? m1_begin_burst_transfer : m0_begin_burst_transfer;
  assign g_write_data  = grant ? m1_write_data           : m0_write_data;
  assign g_burst_count = grant ? m1_burst_count          : m0_burst_count;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk or negedge rest_n) begin
    if (!rest_n) begin
      state <= IDLE;
      grant <= 1'b0;
      last  <= 1'b1;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      grant <= grant_nx;
      last  <= last_nx;
      cnt   <= cnt_nx;
    end
  end

  // NOTE: every output of this block is given a default first; a path that
  // leaves one unassigned would infer a latch.
  always_comb begin
    state_nx               = state;
    grant_nx               = grant;
    last_nx                = last;
    cnt_nx                 = cnt;
    pick                   = 1'b0;
    s_address              = '0;
    s_byte_en              = '0;
    s_write                = 1'b0;
    s_read                 = 1'b0;
    s_write_data           = '0;
    s_begin_burst_transfer = 1'b0;
    s_burst_count          = '0;
    m0_wait_request        = 1'b1;
    m1_wait_request        = 1'b1;
    m0_read_data           = '0;
    m1_read_data           = '0;
    m0_read_data_valid     = 1'b0;
    m1_read_data_valid     = 1'b0;

    unique case (state)
      IDLE: begin
        if (req0 | req1) begin
          // On a tie the port that did not win last time gets the bus.
          pick     = (req0 & req1) ? ~last : req1;
          grant_nx = pick;
          last_nx  = pick;
          cnt_nx   = eff_len(pick ? m1_burst_count : m0_burst_count);
          state_nx = (pick ? m1_write : m0_write) ? WR_BURST : RD_CMD;
        end
      end

      WR_BURST: begin
        s_address              = g_address;
        s_byte_en              = g_byte_en;
        s_write                = g_write;
        s_write_data           = g_write_data;
        s_begin_burst_transfer = g_begin;
        s_burst_count          = g_burst_count;
        if (grant) m1_wait_request = s_wait_request;
        else       m0_wait_request = s_wait_request;
        if (g_write && !s_wait_request) begin
          cnt_nx = cnt - ONE;
          if (cnt == ONE) state_nx = IDLE;
        end
      end

      RD_CMD: begin
        s_address              = g_address;
        s_read                 = g_read;
        s_begin_burst_transfer = g_begin;
        s_burst_count          = g_burst_count;
        if (grant) m1_wait_request = s_wait_request;
        else       m0_wait_request = s_wait_request;
        if (g_read && !s_wait_request) begin
          cnt_nx   = eff_len(g_burst_count);
          state_nx = RD_DATA;
        end
      end

      RD_DATA: begin
        if (grant) begin
          m1_read_data       = s_read_data;
          m1_read_data_valid = s_read_data_valid;
        end else begin
          m0_read_data       = s_read_data;
          m0_read_data_valid = s_read_data_valid;
        end
        if (s_read_data_valid) begin
          cnt_nx = cnt - ONE;
          if (cnt == ONE) state_nx = IDLE;
        end
      end

      default: state_nx = IDLE;
    endcase
  end

endmodule

// File: doc/sdram_avl_arbiter.md
Name: sdram_avl_arbiter

Overview:
- Two-port arbiter sharing the single Avalon-style slave port of sdram_controller between two burst masters.
- Port 0 is the camera frame writer; port 1 is the HDMI frame reader. Either port may issue reads or writes.
- Grants are round-robin and locked for a whole burst, so write beats and read-return beats are never interleaved between masters.

Parameters:
- AW, 32, address width (byte address).
- DW, 32, data width; byte-enable width is DW/8.
- BCW, 8, burst_count width.

Ports:
- clk  in  1  system clock; all logic rising-edge.
- rest_n  in  1  asynchronous active-low reset.
- m0_address, m1_address  in  AW  burst start address.
- m0_byte_en, m1_byte_en  in  DW/8  write byte enables.
- m0_write, m1_write  in  1  write beat valid.
- m0_read, m1_read  in  1  read command valid.
- m0_write_data, m1_write_data  in  DW  write beat data.
- m0_begin_burst_transfer, m1_begin_burst_transfer  in  1  first beat/command of a burst.
- m0_burst_count, m1_burst_count  in  BCW  beats in burst (N).
- m0_wait_request, m1_wait_request  out  1  stall; a beat or command is accepted when valid && !wait_request.
- m0_read_data, m1_read_data  out  DW  returned read data.
- m0_read_data_valid, m1_read_data_valid  out  1  read beat valid.
- s_address  out  AW  to controller.
- s_byte_en  out  DW/8  to controller.
- s_write  out  1  to controller.
- s_read  out  1  to controller.
- s_write_data  out  DW  to controller.
- s_begin_burst_transfer  out  1  to controller.
- s_burst_count  out  BCW  to controller.
- s_wait_request  in  1  controller stall.
- s_read_data  in  DW  controller read data.
- s_read_data_valid  in  1  controller read beat valid.

Behaviour:
- Reset (async, rest_n=0):
  - state=IDLE, grant=0, last=1 (so port 0 wins the first tie), beat counter=0.
  - All s_* command outputs 0.
  - m*_wait_request=1, m*_read_data_valid=0, m*_read_data=0.
  - Reset mid-burst abandons the burst; no recovery is attempted.
- Burst length N = burst_count; N=0 is treated as 1.
- States: IDLE, WR_BURST, RD_CMD, RD_DATA.
- IDLE:
  - A request is (mX_write|mX_read) && mX_begin_burst_transfer.
  - If one port requests, grant it. If both request, grant the port != last.
  - Registered decision: state changes on the next edge; no beat is accepted in IDLE, so both wait_request=1.
  - Load cnt=N, set last=grant.
  - Enter WR_BURST if the granted request has write=1, else RD_CMD. If write and read are both high, write wins.
- WR_BURST:
  - Granted master's command/data signals forwarded combinationally to s_*.
  - mG_wait_request = s_wait_request; the other port's wait_request=1.
  - Each accepted beat (s_write && !s_wait_request) decrements cnt.
  - Beat with cnt==1 accepted -> IDLE.
  - s_begin_burst_transfer = mG_begin_burst_transfer, passed through.
- RD_CMD:
  - Forward s_read, s_address, s_burst_count, s_begin_burst_transfer.
  - On acceptance (s_read && !s_wait_request) -> RD_DATA with cnt=N.
- RD_DATA:
  - s_read=0; both masters wait_request=1, no new command accepted.
  - s_read_data and s_read_data_valid routed combinationally to the granted port only; the other port's read_data_valid=0.
  - Each valid beat decrements cnt; beat with cnt==1 -> IDLE.
- Minimum gap between bursts: one IDLE cycle.
- A new request arriving during a burst waits. The requesting master holds its signals until accepted.
- read_data_valid is never routed to a non-granted port. s_read_data_valid in IDLE is ignored (no port sees it).
- Fairness: with both ports continuously requesting, grants strictly alternate 0,1,0,1.

Test Plan:
- After reset: m0 write burst N=4 at 0x100, data 0x12345678..+3, s_wait_request=0 -> 4 s_write beats on consecutive cycles starting 1 cycle after request; IDLE after beat 4.
- m1 read N=8 at 0x2000 while s_wait_request high for 3 cycles -> s_read held 3 cycles, accepted once. 8 s_read_data_valid beats all appear on m1 only; m0_read_data_valid stays 0.
- m0 write N=255 and m1 read N=16 requested in the same cycle -> m0 granted first (last=1 at reset). m1_wait_request=1 until 255 beats are accepted, then m1 granted after one IDLE cycle.
- Both ports requesting continuously with N=2 each -> grant sequence 0,1,0,1; no port waits more than one burst.
- Burst_count=0 write -> exactly 1 beat forwarded, then IDLE.
- rest_n pulsed low in RD_DATA after 3 of 8 beats -> all outputs return to reset values immediately; next request is arbitrated normally.
